// File: rtl/and_mon_pkg.sv
// Shared types and default parameters for the AND-stage output monitor.
// Latency: n/a (definitions only); backpressure: none.
package and_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        QUAL = 2'd2
    } state_t;

    localparam int MIN_RUN_DEF = 3;
    localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clr wins over a same-cycle increment.
// Latency: 1 cycle from inc/clr to cnt; backpressure: none, holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/and_out_monitor.sv
// Registers the AND-stage output and qualifies runs of consecutive highs.
// Latency: 1 cycle input register plus 1 cycle FSM; backpressure: none.
module and_out_monitor
    import and_mon_pkg::*;
#(
    parameter int MIN_RUN = MIN_RUN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             y_in,
    output logic             y_q,
    output logic             busy,
    output logic [CNT_W-1:0] run_len,
    output logic             run_ok,
    output logic             run_short,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam logic [CNT_W-1:0] LEN_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_RUN);

    state_t           r_state;
    logic             r_y_q;
    logic             r_busy;
    logic [CNT_W-1:0] r_run_len;
    logic             r_run_ok;
    logic             r_run_short;

    state_t           w_next_state;
    logic [CNT_W-1:0] w_next_len;
    logic [CNT_W-1:0] w_len_inc;
    logic             w_ok;
    logic             w_short;

    assign w_len_inc = r_run_len + LEN_ONE;

    // en low aborts any run silently, ahead of y_q.
    always_comb begin
        w_next_state = r_state;
        w_next_len   = r_run_len;
        w_ok         = 1'b0;
        w_short      = 1'b0;
        case (r_state)
            IDLE: begin
                if (en && r_y_q) begin
                    w_next_len = LEN_ONE;
                    if (MIN_RUN == 1) begin
                        w_next_state = QUAL;
                        w_ok         = 1'b1;
                    end else begin
                        w_next_state = RUN;
                    end
                end else begin
                    w_next_len = '0;
                end
            end
            RUN: begin
                if (!en) begin
                    w_next_state = IDLE;
                    w_next_len   = '0;
                end else if (r_y_q) begin
                    w_next_len = w_len_inc;
                    if (w_len_inc == MIN_LEN) begin
                        w_next_state = QUAL;
                        w_ok         = 1'b1;
                    end
                end else begin
                    w_next_state = IDLE;
                    w_next_len   = '0;
                    w_short      = 1'b1;
                end
            end
            QUAL: begin
                if (!en || !r_y_q) begin
                    w_next_state = IDLE;
                    w_next_len   = '0;
                end else if (r_run_len != {CNT_W{1'b1}}) begin
                    w_next_len = w_len_inc;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_len   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_y_q       <= 1'b0;
            r_busy      <= 1'b0;
            r_run_len   <= '0;
            r_run_ok    <= 1'b0;
            r_run_short <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_y_q       <= y_in;
            r_busy      <= (w_next_state != IDLE);
            r_run_len   <= w_next_len;
            r_run_ok    <= w_ok;
            r_run_short <= w_short;
        end
    end

    sat_counter #(.W(CNT_W)) u_pass_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_ok),
        .clr (clr),
        .cnt (pass_cnt)
    );

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_short),
        .clr (clr),
        .cnt (fail_cnt)
    );

    assign y_q       = r_y_q;
    assign busy      = r_busy;
    assign run_len   = r_run_len;
    assign run_ok    = r_run_ok;
    assign run_short = r_run_short;

endmodule
